// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   - default width/count constants
//   - clear-sequencer state encoding
//   - prio_hi_oh(): one-hot select of the highest-index requester; used to
//     resolve several write ports hitting one address (highest port wins)
package regfile_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 5;
  localparam int NREGS_DEF  = 32;
  localparam int NRD_DEF    = 2;
  localparam int NWR_DEF    = 1;
  localparam int NWR_MAX    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Highest set bit of req as a one-hot vector; all-zero when req is zero.
  function automatic logic [NWR_MAX-1:0] prio_hi_oh(input logic [NWR_MAX-1:0] req);
    logic [NWR_MAX-1:0] oh;
    oh = '0;
    for (int i = 0; i < NWR_MAX; i++)
      if (req[i]) oh = NWR_MAX'(1) << i;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback side bus of the register file.
//   ra/rd/rbusy      : NRD read ports (address, data, pending bit)
//   we/wa/wd         : NWR write ports
//   alloc_en/addr    : mark a register pending (new producer in flight)
//   clr / ready      : clear-sweep request, idle indication
// master = pipeline side, slave = register file.
interface regfile_mp_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 1
);
  logic [NRD-1:0][AWIDTH-1:0] ra;
  logic [NRD-1:0][DWIDTH-1:0] rd;
  logic [NRD-1:0]             rbusy;
  logic [NWR-1:0]             we;
  logic [NWR-1:0][AWIDTH-1:0] wa;
  logic [NWR-1:0][DWIDTH-1:0] wd;
  logic                       alloc_en;
  logic [AWIDTH-1:0]          alloc_addr;
  logic                       clr;
  logic                       ready;

  modport master (
    output ra, we, wa, wd, alloc_en, alloc_addr, clr,
    input  rd, rbusy, ready
  );

  modport slave (
    input  ra, we, wa, wd, alloc_en, alloc_addr, clr,
    output rd, rbusy, ready
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits.
//   alloc_vld/alloc_addr : set pending (already filtered for reg 0 / range / idle)
//   wr_vld/wr_addr       : qualified writes; clear pending of their target
//   flush                : clear every pending bit (start of clear sweep)
//   ra, wr_hit           : read addresses and "a same-cycle write hits ra"
//   rbusy                : registered pending bit per read port, hidden when a
//                          same-cycle write retires the producer (BYPASS=1)
module regfile_scoreboard #(
  parameter int NREGS  = 32,
  parameter int AWIDTH = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc_vld,
  input  logic [AWIDTH-1:0]          alloc_addr,
  input  logic [NWR-1:0]             wr_vld,
  input  logic [NWR-1:0][AWIDTH-1:0] wr_addr,
  input  logic [NRD-1:0][AWIDTH-1:0] ra,
  input  logic [NRD-1:0]             wr_hit,
  output logic [NRD-1:0]             rbusy
);

  logic [NREGS-1:0] pend_q, pend_d;

  // Alloc is applied after the write clear so a new producer issued in the
  // same cycle as the old one retires keeps the register pending.
  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NWR; p++)
        if (wr_vld[p] && wr_addr[p] == AWIDTH'(r)) pend_d[r] = 1'b0;
      if (alloc_vld && alloc_addr == AWIDTH'(r)) pend_d[r] = 1'b1;
    end
    if (flush) pend_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic pb;
    // Addresses >= NREGS match nothing and read as not pending.
    always_comb begin
      pb = 1'b0;
      for (int r = 0; r < NREGS; r++)
        if (ra[i] == AWIDTH'(r)) pb = pend_q[r];
    end
    assign rbusy[i] = pb &&
      !((BYPASS != 0) && wr_hit[i] && !(alloc_vld && alloc_addr == ra[i]));
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file (RV32I).
//   clk, rst : clock, async active-high reset (clears array, pending, FSM)
//   bus      : regfile_mp_if slave (read/write ports, alloc, clr/ready)
// Reg 0 and addresses >= NREGS read 0 and are never written or pending.
// Writes on several ports to one address: highest port index wins, both in
// the array and on the bypass path. A clear sweep zeroes regs 1..NREGS-1 one
// per cycle; writes/alloc/clr are ignored and bypass is off while sweeping.
// NWR is limited to 1..4 by the width of the package priority select.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF,
  parameter int BYPASS = 1
) (
  input  logic       clk,
  input  logic       rst,
  regfile_mp_if.slave bus
);

  localparam logic [AWIDTH:0]   NREGS_W = (AWIDTH+1)'(NREGS);
  localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(NREGS-1);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              idle, flush, sweep;
  logic [NWR-1:0]    wvld;
  logic              alloc_vld;
  logic [NRD-1:0]    whit;
  logic [DWIDTH-1:0] mem [NREGS];

  function automatic logic addr_ok(input logic [AWIDTH-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  // ---- clear sequencer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    sweep   = 1'b0;
    case (state_q)
      IDLE: if (bus.clr) begin
        state_d = CLEAR;
        cnt_d   = AWIDTH'(1);
        flush   = 1'b1;
      end
      CLEAR: begin
        sweep = 1'b1;
        cnt_d = cnt_q + AWIDTH'(1);
        // Stop on the last register so the counter never wraps.
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle      = (state_q == IDLE);
  assign bus.ready = idle;

  // ---- qualified writes / alloc (dropped while sweeping) ----
  for (genvar p = 0; p < NWR; p++) begin : g_wv
    assign wvld[p] = idle && bus.we[p] && addr_ok(bus.wa[p]);
  end
  assign alloc_vld = idle && bus.alloc_en && addr_ok(bus.alloc_addr);

  // ---- array: ascending port loop lets the highest port win ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (sweep) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (wvld[p]) mem[bus.wa[p]] <= bus.wd[p];
    end
  end

  // ---- read ports with same-cycle bypass ----
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [NWR_MAX-1:0] hits, oh;
    logic [DWIDTH-1:0]  byp, rdv;

    always_comb begin
      hits = '0;
      for (int p = 0; p < NWR; p++)
        hits[p] = wvld[p] && (bus.wa[p] == bus.ra[i]);
    end

    assign oh = prio_hi_oh(hits);

    always_comb begin
      byp = '0;
      for (int p = 0; p < NWR; p++)
        if (oh[p]) byp = bus.wd[p];
      rdv = '0;
      if (addr_ok(bus.ra[i]))
        rdv = ((BYPASS != 0) && (oh != '0)) ? byp : mem[bus.ra[i]];
    end

    assign whit[i]   = |hits;
    assign bus.rd[i] = rdv;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AWIDTH(AWIDTH),
    .NRD   (NRD),
    .NWR   (NWR),
    .BYPASS(BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .alloc_vld (alloc_vld),
    .alloc_addr(bus.alloc_addr),
    .wr_vld    (wvld),
    .wr_addr   (bus.wa),
    .ra        (bus.ra),
    .wr_hit    (whit),
    .rbusy     (bus.rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test of regfile_mp (NREGS=32, NRD=2, NWR=2,
// BYPASS=1). Inputs change 1ns after the rising edge; outputs are sampled
// 1ns after that, well before the next edge.
module tb_regfile_mp;

  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DWIDTH(32), .AWIDTH(5), .NRD(2), .NWR(2)) bus ();

  regfile_mp #(
    .DWIDTH(32), .AWIDTH(5), .NREGS(NREGS), .NRD(2), .NWR(2), .BYPASS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ra         = '0;
    bus.we         = '0;
    bus.wa         = '0;
    bus.wd         = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;
    bus.clr        = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 1; i < NREGS; i++) begin
      bus.we    = 2'b01;
      bus.wa[0] = 5'(i);
      bus.wd[0] = base | 32'(i);
      tick();
    end
    bus.we = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready);
    end
    rst = 1'b0;
    tick();
    for (int a = 0; a < NREGS; a++) begin
      bus.ra[0] = 5'(a);
      #1;
      checks++;
      if (bus.rd[0] !== 32'h0 || bus.rbusy[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_read a=%0d got rd=%h busy=%b exp rd=0 busy=0", a, bus.rd[0], bus.rbusy[0]);
      end
    end
  endtask

  task automatic test_write_read();
    bus.we = 2'b01; bus.wa[0] = 5'd1; bus.wd[0] = 32'hA5A5A5A5;
    tick();
    bus.we = '0; bus.ra[0] = 5'd1;
    #1;
    checks++;
    if (bus.rd[0] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL wr_rd r1 got=%h exp=a5a5a5a5", bus.rd[0]);
    end
    // Writing reg 0 is dropped, including on the bypass path.
    bus.we = 2'b01; bus.wa[0] = 5'd0; bus.wd[0] = 32'hFFFFFFFF; bus.ra[0] = 5'd0;
    #1;
    checks++;
    if (bus.rd[0] !== 32'h0) begin
      errors++; $display("FAIL wr_rd r0_bypass got=%h exp=0", bus.rd[0]);
    end
    tick();
    bus.we = '0; bus.ra[1] = 5'd1;
    #1;
    checks++;
    if (bus.rd[0] !== 32'h0 || bus.rd[1] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL wr_rd r0_after got r0=%h r1=%h exp r0=0 r1=a5a5a5a5", bus.rd[0], bus.rd[1]);
    end
  endtask

  task automatic test_multi_write();
    bus.we = 2'b11; bus.wa[0] = 5'd3; bus.wa[1] = 5'd3;
    bus.wd[0] = 32'h11111111; bus.wd[1] = 32'h22222222; bus.ra[0] = 5'd3;
    #1;
    checks++;
    if (bus.rd[0] !== 32'h22222222) begin
      errors++; $display("FAIL multi_bypass got=%h exp=22222222", bus.rd[0]);
    end
    tick();
    bus.we = '0;
    #1;
    checks++;
    if (bus.rd[0] !== 32'h22222222) begin
      errors++; $display("FAIL multi_array got=%h exp=22222222", bus.rd[0]);
    end
    // Two ports to different registers, both bypassed then both stored.
    bus.we = 2'b11; bus.wa[0] = 5'd4; bus.wa[1] = 5'd6;
    bus.wd[0] = 32'h44444444; bus.wd[1] = 32'h66666666;
    bus.ra[0] = 5'd6; bus.ra[1] = 5'd4;
    #1;
    checks++;
    if (bus.rd[0] !== 32'h66666666 || bus.rd[1] !== 32'h44444444) begin
      errors++;
      $display("FAIL dual_bypass got %h/%h exp 66666666/44444444", bus.rd[0], bus.rd[1]);
    end
    tick();
    bus.we = '0;
    #1;
    checks++;
    if (bus.rd[0] !== 32'h66666666 || bus.rd[1] !== 32'h44444444) begin
      errors++;
      $display("FAIL dual_array got %h/%h exp 66666666/44444444", bus.rd[0], bus.rd[1]);
    end
  endtask

  task automatic test_scoreboard();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd5;
    tick();
    bus.alloc_en = 1'b0; bus.ra[0] = 5'd5; bus.ra[1] = 5'd6;
    #1;
    checks++;
    if (bus.rbusy !== 2'b01) begin
      errors++; $display("FAIL sb_alloc got=%b exp=01", bus.rbusy);
    end
    bus.we = 2'b01; bus.wa[0] = 5'd5; bus.wd[0] = 32'h55555555;
    #1;
    checks++;
    if (bus.rbusy[0] !== 1'b0 || bus.rd[0] !== 32'h55555555) begin
      errors++;
      $display("FAIL sb_wr_same got busy=%b rd=%h exp busy=0 rd=55555555", bus.rbusy[0], bus.rd[0]);
    end
    tick();
    bus.we = '0;
    #1;
    checks++;
    if (bus.rbusy[0] !== 1'b0) begin
      errors++; $display("FAIL sb_wr_after got=%b exp=0", bus.rbusy[0]);
    end
    // Alloc and write to the same register: new producer wins.
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd5;
    bus.we = 2'b01; bus.wa[0] = 5'd5; bus.wd[0] = 32'h5A5A5A5A;
    tick();
    #1;
    checks++;
    if (bus.rbusy[0] !== 1'b1) begin
      errors++; $display("FAIL sb_alloc_wr_same got=%b exp=1", bus.rbusy[0]);
    end
    tick();
    bus.alloc_en = 1'b0; bus.we = '0;
    #1;
    checks++;
    if (bus.rbusy[0] !== 1'b1) begin
      errors++; $display("FAIL sb_alloc_wr_after got=%b exp=1", bus.rbusy[0]);
    end
    bus.we = 2'b10; bus.wa[1] = 5'd5; bus.wd[1] = 32'h0;
    tick();
    bus.we = '0;
    #1;
    checks++;
    if (bus.rbusy[0] !== 1'b0) begin
      errors++; $display("FAIL sb_retire got=%b exp=0", bus.rbusy[0]);
    end
  endtask

  task automatic test_clear();
    int n;
    fill(32'hC0000000);
    bus.ra[0] = 5'd17;
    #1;
    checks++;
    if (bus.rd[0] !== 32'hC0000011) begin
      errors++; $display("FAIL clr_fill got=%h exp=c0000011", bus.rd[0]);
    end
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd7;
    tick();
    bus.alloc_en = 1'b0; bus.ra[0] = 5'd7;
    #1;
    checks++;
    if (bus.rbusy[0] !== 1'b1) begin
      errors++; $display("FAIL clr_pre_busy got=%b exp=1", bus.rbusy[0]);
    end
    bus.clr = 1'b1;
    tick();
    // First sweep cycle: writes/alloc driven, must be ignored; no bypass.
    bus.clr = 1'b0;
    bus.we = 2'b01; bus.wa[0] = 5'd31; bus.wd[0] = 32'hDEADBEEF;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd9;
    bus.ra[1] = 5'd31;
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.rd[1] !== 32'hC000001F || bus.rbusy[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_first got ready=%b rd=%h busy=%b exp ready=0 rd=c000001f busy=0",
               bus.ready, bus.rd[1], bus.rbusy[0]);
    end
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
    bus.we = '0; bus.alloc_en = 1'b0;
    checks++;
    if (n !== 31) begin
      errors++; $display("FAIL clr_len got=%0d exp=31", n);
    end
    for (int a = 0; a < NREGS; a++) begin
      bus.ra[0] = 5'(a);
      #1;
      checks++;
      if (bus.rd[0] !== 32'h0 || bus.rbusy[0] !== 1'b0) begin
        errors++;
        $display("FAIL clr_after a=%0d got rd=%h busy=%b exp rd=0 busy=0", a, bus.rd[0], bus.rbusy[0]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    tick();
    fill(32'h30000000);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    repeat (9) tick();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pre got ready=%b exp=0", bus.ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready got=%b exp=1", bus.ready);
    end
    for (int a = 0; a < NREGS; a++) begin
      bus.ra[0] = 5'(a);
      #1;
      checks++;
      if (bus.rd[0] !== 32'h0 || bus.rbusy[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_read a=%0d got rd=%h busy=%b exp rd=0 busy=0", a, bus.rd[0], bus.rbusy[0]);
      end
    end
    tick();
    rst = 1'b0;
    tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 31) begin
      errors++; $display("FAIL rst_mid_resweep got=%0d exp=31", n);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_multi_write();
    test_scoreboard();
    test_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
